// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

   localparam int unsigned LAT_DEFAULT = 2;
   localparam int unsigned DATA_W      = 16;
   localparam int unsigned CNT_W       = 4;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   // Command presented to the memory for the access in flight
   typedef struct packed {
      logic              we;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between the fetch and data ports,
// alternating grants on back-to-back contention and counting contention cycles.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned LAT = LAT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hlt,
   input  logic              if_req,
   input  logic [DATA_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              dm_re,
   input  logic              dm_we,
   input  logic [DATA_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] conflict_cnt
);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_dm_q, last_dm_d;
   logic              mem_en_q, mem_en_d;
   mem_cmd_t          cmd_q, cmd_d;
   logic [DATA_W-1:0] conflict_cnt_q, conflict_cnt_d;
   logic              dm_req;
   logic              grant_dm;

   // Next-state, grant decision and completion steering
   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      cnt_d          = cnt_q;
      last_dm_d      = last_dm_q;
      mem_en_d       = 1'b0;
      cmd_d          = cmd_q;
      conflict_cnt_d = conflict_cnt_q;
      if_ready       = 1'b0;
      dm_ready       = 1'b0;
      if_rdata       = '0;
      dm_rdata       = '0;
      dm_req         = dm_re | dm_we;
      grant_dm       = 1'b0;

      case (state_q)
         IDLE: begin
            if (!hlt && (if_req || dm_req)) begin
               // Data wins a tie unless it won the previous grant
               grant_dm = dm_req && !(if_req && last_dm_q);
               if (if_req && dm_req && (conflict_cnt_q != '1)) begin
                  conflict_cnt_d = conflict_cnt_q + DATA_W'(1);
               end
               owner_d     = grant_dm ? OWN_DM : OWN_IF;
               last_dm_d   = grant_dm;
               mem_en_d    = 1'b1;
               cmd_d.we    = grant_dm & dm_we;
               cmd_d.addr  = grant_dm ? dm_addr : if_addr;
               cmd_d.wdata = dm_wdata;
               cnt_d       = CNT_W'(LAT);
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               if (owner_q == OWN_DM) begin
                  dm_ready = 1'b1;
                  dm_rdata = mem_rdata;
               end else begin
                  if_ready = 1'b1;
                  if_rdata = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         owner_q        <= OWN_IF;
         cnt_q          <= '0;
         last_dm_q      <= 1'b0;
         mem_en_q       <= 1'b0;
         cmd_q          <= '0;
         conflict_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         cnt_q          <= cnt_d;
         last_dm_q      <= last_dm_d;
         mem_en_q       <= mem_en_d;
         cmd_q          <= cmd_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign mem_en       = mem_en_q;
   assign mem_we       = cmd_q.we;
   assign mem_addr     = cmd_q.addr;
   assign mem_wdata    = cmd_q.wdata;
   assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a timestamp-based transaction model
// with a latency-accurate memory responder.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int unsigned LAT = 2;
   localparam int MODE_RAND = 0;
   localparam int MODE_BOTH = 1;
   localparam int MODE_NONE = 2;
   localparam int MODE_HALT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hlt, if_req, if_ready, dm_re, dm_we, dm_ready, mem_en, mem_we;
   logic [15:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, conflict_cnt;

   mem_arbiter #(.LAT(LAT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .hlt          (hlt),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_rdata     (if_rdata),
      .if_ready     (if_ready),
      .dm_re        (dm_re),
      .dm_we        (dm_we),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_rdata     (dm_rdata),
      .dm_ready     (dm_ready),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic [15:0] tb_mem  [256];
   logic [15:0] ref_mem [256];
   int          en_cyc;
   logic [15:0] en_addr;

   // Reference model: one record of the latest grant, located in time by its cycle
   int          g_cyc;
   bit          g_dm, g_we, m_last_dm;
   logic [15:0] g_addr, g_wdata, g_rdata, m_cnt;
   bit          done_if, done_dm;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      g_cyc     = -1000;
      g_dm      = 1'b0;
      g_we      = 1'b0;
      g_addr    = '0;
      g_wdata   = '0;
      g_rdata   = '0;
      m_last_dm = 1'b0;
      m_cnt     = '0;
      en_cyc    = -1000;
      en_addr   = '0;
   endtask

   task automatic new_dm();
      int unsigned k;
      k        = $urandom_range(0, 7);
      dm_we    = (k <= 2);
      dm_re    = (k == 0) || (k >= 3);
      dm_addr  = 16'($urandom);
      dm_wdata = 16'($urandom);
   endtask

   // One clock: check outputs at negedge, advance the model, then drive the next cycle
   task automatic run_cycle(input int mode);
      bit fin, idle, dm_any, gd;
      @(negedge clk);
      if (mem_en) begin
         en_cyc  = cyc;
         en_addr = mem_addr;
         if (mem_we) tb_mem[mem_addr[7:0]] = mem_wdata;
      end
      fin     = (cyc == g_cyc + 1 + int'(LAT));
      idle    = (cyc >  g_cyc + 1 + int'(LAT));
      done_if = fin && !g_dm;
      done_dm = fin && g_dm;
      check_eq("mem_en",       16'(mem_en),   16'(cyc == g_cyc + 1));
      check_eq("mem_addr",     mem_addr,      g_addr);
      check_eq("mem_we",       16'(mem_we),   16'(g_we));
      check_eq("mem_wdata",    mem_wdata,     g_wdata);
      check_eq("if_ready",     16'(if_ready), 16'(done_if));
      check_eq("dm_ready",     16'(dm_ready), 16'(done_dm));
      check_eq("if_rdata",     if_rdata,      done_if ? g_rdata : 16'h0000);
      if (!(done_dm && g_we)) check_eq("dm_rdata", dm_rdata, done_dm ? g_rdata : 16'h0000);
      check_eq("conflict_cnt", conflict_cnt,  m_cnt);

      dm_any = dm_re || dm_we;
      if (idle && !hlt && (if_req || dm_any)) begin
         gd = dm_any && !(if_req && m_last_dm);
         if (if_req && dm_any && (m_cnt != 16'hFFFF)) m_cnt++;
         g_cyc     = cyc;
         g_dm      = gd;
         g_addr    = gd ? dm_addr : if_addr;
         g_we      = gd && dm_we;
         g_wdata   = dm_wdata;
         g_rdata   = ref_mem[g_addr[7:0]];
         if (g_we) ref_mem[g_addr[7:0]] = dm_wdata;
         m_last_dm = gd;
      end

      @(posedge clk);
      #1;
      cyc++;
      mem_rdata = (cyc == en_cyc + int'(LAT)) ? tb_mem[en_addr[7:0]] : 16'($urandom);
      if (done_if) if_req = 1'b0;
      if (done_dm) begin
         dm_re = 1'b0;
         dm_we = 1'b0;
      end
      hlt = 1'b0;
      case (mode)
         MODE_RAND: begin
            if (!if_req && ($urandom_range(0, 2) == 0)) begin
               if_req  = 1'b1;
               if_addr = 16'($urandom);
            end
            if (!dm_re && !dm_we && ($urandom_range(0, 2) == 0)) new_dm();
            hlt = ($urandom_range(0, 7) == 0);
         end
         MODE_BOTH: begin
            if (!if_req) begin
               if_req  = 1'b1;
               if_addr = 16'($urandom);
            end
            if (!dm_re && !dm_we) begin
               dm_re    = 1'b1;
               dm_addr  = 16'($urandom);
               dm_wdata = 16'($urandom);
            end
         end
         MODE_HALT: hlt = 1'b1;
         default: ;
      endcase
   endtask

   initial begin
      rst_n = 1'b0; hlt = 1'b0; if_req = 1'b0; dm_re = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
      for (int i = 0; i < 256; i++) begin
         tb_mem[i]  = 16'(i * 257) ^ 16'h5A5A;
         ref_mem[i] = tb_mem[i];
      end
      tb_mem[4]  = 16'hB123;
      ref_mem[4] = 16'hB123;
      model_reset();

      #12;
      check_eq("rst_if_ready",  16'(if_ready), 16'h0000);
      check_eq("rst_dm_ready",  16'(dm_ready), 16'h0000);
      check_eq("rst_if_rdata",  if_rdata,      16'h0000);
      check_eq("rst_dm_rdata",  dm_rdata,      16'h0000);
      check_eq("rst_mem_en",    16'(mem_en),   16'h0000);
      check_eq("rst_mem_we",    16'(mem_we),   16'h0000);
      check_eq("rst_mem_addr",  mem_addr,      16'h0000);
      check_eq("rst_mem_wdata", mem_wdata,     16'h0000);
      check_eq("rst_conflict",  conflict_cnt,  16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc++;

      // Single fetch of a known word
      if_req = 1'b1; if_addr = 16'h0004;
      repeat (LAT + 3) run_cycle(MODE_NONE);

      // Data write followed by a read-back of the same word
      dm_we = 1'b1; dm_addr = 16'h0010; dm_wdata = 16'hBEEF;
      repeat (LAT + 3) run_cycle(MODE_NONE);
      dm_re = 1'b1; dm_addr = 16'h0010;
      repeat (LAT + 3) run_cycle(MODE_NONE);

      // Sustained contention: grants must alternate
      repeat (4 * (LAT + 2) + 1) run_cycle(MODE_BOTH);
      repeat (2 * (LAT + 2) + 2) run_cycle(MODE_NONE);

      // Halt raised mid-fetch: fetch completes, pending data read waits
      if_req = 1'b1; if_addr = 16'h0042;
      repeat (2) run_cycle(MODE_NONE);
      hlt = 1'b1; dm_re = 1'b1; dm_addr = 16'h0020;
      repeat (8) run_cycle(MODE_HALT);
      repeat (LAT + 4) run_cycle(MODE_NONE);

      // Random traffic
      repeat (3000) run_cycle(MODE_RAND);
      repeat (2 * (LAT + 2) + 2) run_cycle(MODE_NONE);

      // Reset in the middle of a data read aborts it
      dm_re = 1'b1; dm_addr = 16'h0030;
      repeat (2) run_cycle(MODE_NONE);
      rst_n = 1'b0;
      #1;
      check_eq("abort_dm_ready", 16'(dm_ready), 16'h0000);
      check_eq("abort_dm_rdata", dm_rdata,      16'h0000);
      check_eq("abort_mem_en",   16'(mem_en),   16'h0000);
      check_eq("abort_mem_addr", mem_addr,      16'h0000);
      check_eq("abort_conflict", conflict_cnt,  16'h0000);
      dm_re = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      repeat (LAT + 4) run_cycle(MODE_NONE);

      // Preload the counter near its ceiling, then contend past it
      force dut.conflict_cnt_q = 16'hFFFD;
      m_cnt = 16'hFFFD;
      run_cycle(MODE_NONE);
      release dut.conflict_cnt_q;
      repeat (6 * (LAT + 2)) run_cycle(MODE_BOTH);
      repeat (2 * (LAT + 2) + 2) run_cycle(MODE_NONE);
      check_eq("sat_hold", conflict_cnt, 16'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
